// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//   Collects FRAME_LEN results from the 4-bit ripple adder stage. Each result
//   is {c_out, sum[3:0]} treated as a 5-bit unsigned value. The frame total
//   saturates at 2^ACC_W-1, and carry-outs are counted. The finished frame is
//   then held on a valid/ready output until the consumer takes it.
//
//   Ports
//     clk, rst_n     : rising-edge clock, async active-low reset
//     in_valid       : adder result valid
//     in_ready       : block accepts a result this cycle (ACCUM state)
//     in_sum/in_cout : adder result, sampled only on accept
//     clear          : synchronous frame abort (beats both handshakes)
//     out_valid      : frame result valid (HOLD state)
//     out_ready      : consumer accepts the frame result
//     out_total      : saturated frame total (running total while in ACCUM)
//     out_carries    : number of accepted results with in_cout=1
//     out_ovf        : sticky, set when the total saturated during this frame
module adder_result_accumulator #(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_ovf
);

  localparam int unsigned     SUM_W    = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   car_q, car_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_c;
  logic [SUM_W-1:0]   sum_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      car_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      car_q       <= car_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: accumulate in ACCUM, wait for consumer in HOLD, clear wins
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    car_d     = car_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    accept_c  = in_valid & in_ready_q;
    // One spare bit on the adder exposes overflow past ACC_MAX
    sum_c     = {1'b0, acc_q} + SUM_W'({in_cout, in_sum});
    cnt_inc_c = cnt_q + CNT_W'(1);

    case (state_q)
      ST_ACCUM: begin
        if (accept_c) begin
          if (sum_c[ACC_W]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_c[ACC_W-1:0];
          end
          car_d = car_q + CNT_W'(in_cout);
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == LAST) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          car_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      car_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_total   = acc_q;
  assign out_carries = car_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: directed vector table, a mid-frame
// reset sequence and randomized traffic against a behavioural frame model.
module tb_adder_result_accumulator;

  localparam int unsigned ACC_W     = 8;
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int          MAXV      = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_cout;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_carries;
  logic             out_ovf;

  adder_result_accumulator #(
    .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_carries(out_carries), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural frame model
  int m_total, m_car, m_cnt;
  bit m_ovf, m_hold;

  function automatic void model_zero();
    m_total = 0; m_car = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
  endfunction

  function automatic void model_step(bit v, int s, bit c, bit clr, bit ordy);
    int value;
    if (clr) begin
      model_zero();
    end else if (m_hold) begin
      if (ordy) model_zero();
    end else if (v) begin
      value = s + (c ? 16 : 0);
      if (m_total + value > MAXV) begin
        m_total = MAXV;
        m_ovf   = 1'b1;
      end else begin
        m_total = m_total + value;
      end
      m_car = m_car + (c ? 1 : 0);
      m_cnt = m_cnt + 1;
      if (m_cnt == FRAME_LEN) m_hold = 1'b1;
    end
  endfunction

  task automatic cmp(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_model(string tag);
    cmp({tag, ".out_valid"},   int'(out_valid),   int'(m_hold));
    cmp({tag, ".in_ready"},    int'(in_ready),    int'(!m_hold));
    cmp({tag, ".out_total"},   int'(out_total),   m_total);
    cmp({tag, ".out_carries"}, int'(out_carries), m_car);
    cmp({tag, ".out_ovf"},     int'(out_ovf),     int'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic apply(bit v, int s, bit c, bit clr, bit ordy, string tag);
    in_valid  = v;
    in_sum    = 4'(s);
    in_cout   = c;
    clear     = clr;
    out_ready = ordy;
    model_step(v, s, c, clr, ordy);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    int   rep;
    bit   v;
    int   s;
    bit   c;
    bit   clr;
    bit   ordy;
    bit   e_val;
    int   e_tot;
    int   e_car;
    bit   e_ovf;
    bit   e_rdy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // rep, v, sum, cout, clear, out_ready | expected after last rep
    tbl[0]  = '{16, 1, 5,  0, 0, 0,  1, 80,  0,  0, 0};  // frame of v=5
    tbl[1]  = '{3,  1, 1,  0, 0, 0,  1, 80,  0,  0, 0};  // HOLD stable, input ignored
    tbl[2]  = '{1,  1, 1,  0, 0, 1,  0, 0,   0,  0, 1};  // handshake, then zeroed
    tbl[3]  = '{8,  1, 15, 1, 0, 0,  0, 248, 8,  0, 1};  // 8 x 31
    tbl[4]  = '{1,  1, 15, 1, 0, 0,  0, 255, 9,  1, 1};  // saturates
    tbl[5]  = '{7,  1, 15, 1, 0, 0,  1, 255, 16, 1, 0};  // frame end, saturated
    tbl[6]  = '{1,  0, 0,  0, 0, 1,  0, 0,   0,  0, 1};
    tbl[7]  = '{5,  1, 7,  0, 0, 0,  0, 35,  0,  0, 1};
    tbl[8]  = '{1,  1, 7,  0, 1, 0,  0, 0,   0,  0, 1};  // clear with valid input
    tbl[9]  = '{16, 1, 2,  0, 0, 0,  1, 32,  0,  0, 0};
    tbl[10] = '{1,  0, 0,  0, 0, 1,  0, 0,   0,  0, 1};
    tbl[11] = '{16, 1, 5,  0, 0, 0,  1, 80,  0,  0, 0};
    tbl[12] = '{1,  0, 0,  0, 1, 1,  0, 0,   0,  0, 1};  // clear + out_ready in HOLD
    tbl[13] = '{1,  0, 0,  0, 0, 0,  0, 0,   0,  0, 1};
    tbl[14] = '{2,  1, 3,  1, 0, 1,  0, 38,  2,  0, 1};  // out_ready ignored in ACCUM

    rst_n = 1'b0; in_valid = 1'b0; in_sum = 4'd0; in_cout = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp("reset.in_ready",    int'(in_ready),    1);
    cmp("reset.out_valid",   int'(out_valid),   0);
    cmp("reset.out_total",   int'(out_total),   0);
    cmp("reset.out_carries", int'(out_carries), 0);
    cmp("reset.out_ovf",     int'(out_ovf),     0);

    for (int i = 0; i < 15; i++) begin
      for (int r = 0; r < tbl[i].rep; r++)
        apply(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].clr, tbl[i].ordy, $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.exp_valid", i),   int'(out_valid),   int'(tbl[i].e_val));
      cmp($sformatf("tbl%0d.exp_total", i),   int'(out_total),   tbl[i].e_tot);
      cmp($sformatf("tbl%0d.exp_carries", i), int'(out_carries), tbl[i].e_car);
      cmp($sformatf("tbl%0d.exp_ovf", i),     int'(out_ovf),     int'(tbl[i].e_ovf));
      cmp($sformatf("tbl%0d.exp_ready", i),   int'(in_ready),    int'(tbl[i].e_rdy));
    end

    // Asynchronous reset in the middle of a frame, between clock edges
    apply(0, 0, 0, 1, 0, "rst_pre");
    for (int i = 0; i < 10; i++) apply(1, 9, 1, 0, 0, "rst_fill");
    #3;
    rst_n = 1'b0;
    #1;
    model_zero();
    cmp("async_rst.out_valid",   int'(out_valid),   0);
    cmp("async_rst.out_total",   int'(out_total),   0);
    cmp("async_rst.out_carries", int'(out_carries), 0);
    cmp("async_rst.out_ovf",     int'(out_ovf),     0);
    cmp("async_rst.in_ready",    int'(in_ready),    1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) apply(1, 1, 0, 0, 0, "post_rst");
    cmp("post_rst.frame_total", int'(out_total), 16);
    cmp("post_rst.frame_valid", int'(out_valid), 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      apply($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
